// File: rtl/sfifo_wb_bridge.sv
// sfifo_wb_bridge: WISHBONE slave bridging a sync FIFO, byte mailbox, BP tick counter, RT command, DIN/DOUT/ESTOP and ADC words
// Ports: wb_clk_i/wb_rst_n_i clock and async active-low reset; wb_* WISHBONE slave (word index on wb_adr_i);
// sfifo_* FIFO pop side; mbox_* byte mailbox push side; sfifo_bp_tick_i async tick; rt_cmd_i/rt_cmd_rst_o
// RT command and its read strobe; alarm_i forces DOUT to ESTOP; din_i/adc_i read-only inputs; dout_o outputs.
module sfifo_wb_bridge #(
  parameter int WB_AW     = 8,
  parameter int SFIFO_DW  = 16,
  parameter int DIN_N     = 2,
  parameter int DOUT_N    = 1,
  parameter int ADC_CH    = 16,
  parameter int ADC_W     = 12,
  parameter int SFIFO_TMO = 1023
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [3:0]              wb_sel_i,
  input  logic [WB_AW-1:2]        wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    sfifo_rd_o,
  input  logic                    sfifo_empty_i,
  input  logic                    sfifo_full_i,
  input  logic [SFIFO_DW-1:0]     sfifo_di,
  output logic                    mbox_wr_o,
  output logic [7:0]              mbox_do_o,
  input  logic                    mbox_full_i,
  input  logic                    mbox_afull_i,
  input  logic                    mbox_empty_i,
  input  logic                    sfifo_bp_tick_i,
  input  logic [31:0]             rt_cmd_i,
  output logic                    rt_cmd_rst_o,
  input  logic                    alarm_i,
  input  logic [32*DIN_N-1:0]     din_i,
  input  logic [ADC_W*ADC_CH-1:0] adc_i,
  output logic [32*DOUT_N-1:0]    dout_o
);
  localparam int IW = WB_AW - 2;
  localparam int TW = $clog2(SFIFO_TMO + 1);
  typedef enum logic {IDLE, SEND} st_t;
  st_t         r_state, w_nstate;
  logic [1:0]  r_lane;
  logic [31:0] r_mdat;
  logic [3:0]  r_msel;
  logic [TW-1:0] r_wait;
  logic [2:0]  r_sync;
  logic [31:0] r_bp, r_rt, r_dat;
  logic        r_ack, r_err, r_rd, r_rt_d, r_tmo;
  logic [31:0] r_dout [DOUT_N];
  logic [31:0] r_estop [DOUT_N];
  logic [IW-1:0] w_idx;
  logic [31:0] w_rdata, w_sf_data;
  logic w_req, w_sf_sel, w_sf_wait, w_tmo, w_mb_sel, w_mb_stall, w_go, w_wr, w_rt_sel, w_mb_acc, w_adv, w_mb_wr;
  assign w_idx      = wb_adr_i;
  // masking with ack/err keeps a held strobe from being serviced twice in a row
  assign w_req      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign w_sf_sel   = w_req & ~wb_we_i & (w_idx == IW'(2));
  assign w_sf_wait  = w_sf_sel & sfifo_empty_i;
  assign w_tmo      = w_sf_wait & (r_wait == TW'(SFIFO_TMO - 1));
  assign w_mb_sel   = w_req & wb_we_i & (w_idx == IW'(3));
  assign w_mb_stall = w_mb_sel & ((r_state == SEND) | mbox_full_i);
  assign w_go       = w_req & ~w_sf_wait & ~w_mb_stall;
  assign w_wr       = w_go & wb_we_i;
  assign w_mb_acc   = w_go & w_mb_sel;
  assign w_rt_sel   = w_req & ~wb_we_i & (w_idx == IW'(4));
  assign w_sf_data  = 32'(sfifo_di) << (32 - SFIFO_DW);
  assign wb_dat_o     = r_dat;
  assign wb_ack_o     = r_ack;
  assign wb_err_o     = r_err;
  assign sfifo_rd_o   = r_rd;
  assign rt_cmd_rst_o = w_rt_sel | r_rt_d;
  assign mbox_wr_o    = w_mb_wr;
  for (genvar g = 0; g < DOUT_N; g++) begin : g_dout
    assign dout_o[32*g +: 32] = r_dout[g];
  end
  always_comb begin
    w_rdata = '0;
    if (w_idx == IW'(0)) w_rdata = r_bp;
    if (w_idx == IW'(1)) w_rdata = {26'd0, r_tmo, mbox_empty_i, mbox_afull_i, mbox_full_i, sfifo_full_i, sfifo_empty_i};
    if (w_idx == IW'(2)) w_rdata = w_sf_data;
    if (w_idx == IW'(4)) w_rdata = r_rt;
    if (w_idx == IW'(5)) w_rdata = {31'd0, r_tmo};
    for (int i = 0; i < DIN_N; i++) if (w_idx == IW'(8 + i)) w_rdata = din_i[32*i +: 32];
    for (int i = 0; i < DOUT_N; i++) begin
      if (w_idx == IW'(12 + i)) w_rdata = r_dout[i];
      if (w_idx == IW'(16 + i)) w_rdata = r_estop[i];
    end
    for (int k = 0; k < ADC_CH/2; k++)
      if (w_idx == IW'(32 + k)) w_rdata = {16'(adc_i[2*k*ADC_W +: ADC_W]), 16'(adc_i[(2*k+1)*ADC_W +: ADC_W])};
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_rd   <= 1'b0;
      r_dat  <= '0;
      r_wait <= '0;
      r_tmo  <= 1'b0;
      r_sync <= '0;
      r_bp   <= '0;
      r_rt   <= '0;
      r_rt_d <= 1'b0;
    end else begin
      r_ack  <= w_go;
      r_err  <= w_tmo;
      r_rd   <= w_go & w_sf_sel;
      r_rt   <= rt_cmd_i;
      r_rt_d <= w_rt_sel;
      if (w_go & ~wb_we_i) r_dat <= w_rdata;
      r_wait <= (w_sf_wait & ~w_tmo) ? r_wait + 1'b1 : '0;
      if (w_tmo) r_tmo <= 1'b1;
      else if (w_wr & (w_idx == IW'(5)) & wb_sel_i[0] & wb_dat_i[0]) r_tmo <= 1'b0;
      // two flops resynchronise the tick, the third detects its rising edge
      r_sync <= {r_sync[1:0], sfifo_bp_tick_i};
      if (r_sync[1] & ~r_sync[2]) r_bp <= r_bp + 1'b1;
    end
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < DOUT_N; i++) begin
        r_dout[i]  <= '0;
        r_estop[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DOUT_N; i++) begin
        for (int b = 0; b < 4; b++)
          if (w_wr & wb_sel_i[b] & (w_idx == IW'(16 + i))) r_estop[i][8*b +: 8] <= wb_dat_i[8*b +: 8];
        if (alarm_i) r_dout[i] <= r_estop[i];
        else for (int b = 0; b < 4; b++)
          if (w_wr & wb_sel_i[b] & (w_idx == IW'(12 + i))) r_dout[i][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= IDLE;
      r_lane  <= '0;
      r_mdat  <= '0;
      r_msel  <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_mb_acc) begin
        r_mdat <= wb_dat_i;
        r_msel <= wb_sel_i;
        r_lane <= '0;
      end else if ((r_state == SEND) & w_adv) r_lane <= r_lane + 1'b1;
    end
  end
  always_comb begin
    w_adv    = ~r_msel[r_lane] | ~mbox_full_i;
    w_nstate = (r_state == IDLE) ? ((w_mb_acc & |wb_sel_i) ? SEND : IDLE)
                                 : ((w_adv & (r_lane == 2'd3)) ? IDLE : SEND);
  end
  always_comb begin
    w_mb_wr   = (r_state == SEND) & r_msel[r_lane] & ~mbox_full_i;
    mbox_do_o = r_mdat[8*r_lane +: 8];
  end
endmodule

// File: tb/tb_sfifo_wb_bridge.sv
// tb_sfifo_wb_bridge: directed self-checking bench for sfifo_wb_bridge
module tb_sfifo_wb_bridge;
  logic clk = 0, rst_n = 0;
  logic cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [7:2] adr = 0;
  logic [31:0] dat_i = 0, dat_o;
  logic ack, err, sf_rd, sf_empty = 1, sf_full = 0;
  logic [15:0] sf_di = 0;
  logic mb_wr, mb_full = 0, mb_afull = 0, mb_empty = 1;
  logic [7:0] mb_do;
  logic bp_tick = 0, rt_rst, alarm = 0;
  logic [31:0] rt_cmd = 32'hDEADBEEF;
  logic [63:0] din = {32'hCAFEF00D, 32'h12345678};
  logic [191:0] adc;
  logic [31:0] dout;
  int vec = 0, miscmp = 0;
  int rd_cnt = 0, rt_cnt = 0, mb_bad = 0;
  logic [7:0] mq[$];
  sfifo_wb_bridge #(.SFIFO_TMO(8)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .wb_err_o(err), .sfifo_rd_o(sf_rd), .sfifo_empty_i(sf_empty), .sfifo_full_i(sf_full),
    .sfifo_di(sf_di), .mbox_wr_o(mb_wr), .mbox_do_o(mb_do), .mbox_full_i(mb_full),
    .mbox_afull_i(mb_afull), .mbox_empty_i(mb_empty), .sfifo_bp_tick_i(bp_tick),
    .rt_cmd_i(rt_cmd), .rt_cmd_rst_o(rt_rst), .alarm_i(alarm), .din_i(din), .adc_i(adc), .dout_o(dout));
  always #5 clk = ~clk;
  initial for (int j = 0; j < 16; j++) adc[12*j +: 12] = 12'h100 + 12'(j);
  always @(negedge clk) if (rst_n) begin
    if (mb_wr) begin
      mq.push_back(mb_do);
      if (mb_full) mb_bad++;
    end
    if (sf_rd) rd_cnt++;
    if (rt_rst) rt_cnt++;
  end
  logic [31:0] d;
  logic a, e;
  int n, q0, c0;
  task automatic xfer(input logic w, input logic [5:0] ad, input logic [31:0] wd, input logic [3:0] s, input int lim,
                      output logic [31:0] rd, output logic ak, output logic er, output int cnt);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = ad; dat_i = wd; sel = s;
    ak = 0; er = 0; rd = 0; cnt = 0;
    for (int i = 1; i <= lim; i++) begin
      @(posedge clk); #1;
      if (ack || err) begin ak = ack; er = err; rd = dat_o; cnt = i; break; end
    end
    cyc = 0; stb = 0; we = 0;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if ({dat_o, ack, err, sf_rd, mb_wr, mb_do, rt_rst, dout} !== '0) begin miscmp++; $display("FAIL reset_outputs got=%h %b%b%b%b %h %b %h exp=all zero", dat_o, ack, err, sf_rd, mb_wr, mb_do, rt_rst, dout); end
    rst_n = 1;
  endtask
  task automatic test_decode();
    xfer(0, 6'd1, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 32'h11 || a !== 1 || n != 1) begin miscmp++; $display("FAIL status got=%h ack=%b n=%0d exp=00000011 ack=1 n=1", d, a, n); end
    xfer(0, 6'd8, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 32'h12345678) begin miscmp++; $display("FAIL din0 got=%h exp=12345678", d); end
    xfer(0, 6'd9, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 32'hCAFEF00D) begin miscmp++; $display("FAIL din1 got=%h exp=cafef00d", d); end
    xfer(0, 6'd10, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 0 || a !== 1) begin miscmp++; $display("FAIL din_oor got=%h ack=%b exp=0 ack=1", d, a); end
    xfer(0, 6'h21, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 32'h01020103) begin miscmp++; $display("FAIL adc1 got=%h exp=01020103", d); end
    xfer(0, 6'h27, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 32'h010E010F) begin miscmp++; $display("FAIL adc7 got=%h exp=010e010f", d); end
    xfer(0, 6'h28, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 0 || a !== 1) begin miscmp++; $display("FAIL adc_oor got=%h ack=%b exp=0 ack=1", d, a); end
    xfer(0, 6'd6, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 0 || a !== 1) begin miscmp++; $display("FAIL unmapped got=%h ack=%b exp=0 ack=1", d, a); end
    xfer(0, 6'd3, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 0 || a !== 1) begin miscmp++; $display("FAIL mbox_read got=%h ack=%b exp=0 ack=1", d, a); end
    c0 = rt_cnt;
    xfer(0, 6'd4, 0, 4'hF, 20, d, a, e, n);
    repeat (2) @(posedge clk);
    vec++; if (d !== 32'hDEADBEEF) begin miscmp++; $display("FAIL rt_cmd got=%h exp=deadbeef", d); end
    vec++; if (rt_cnt - c0 != 2) begin miscmp++; $display("FAIL rt_rst_cycles got=%0d exp=2", rt_cnt - c0); end
  endtask
  task automatic test_sfifo();
    sf_empty = 0; sf_di = 16'hBEEF; c0 = rd_cnt;
    xfer(0, 6'd2, 0, 4'hF, 20, d, a, e, n);
    repeat (2) @(posedge clk);
    vec++; if (d !== 32'hBEEF0000 || a !== 1 || n != 1) begin miscmp++; $display("FAIL sfifo_read got=%h ack=%b n=%0d exp=beef0000 ack=1 n=1", d, a, n); end
    vec++; if (rd_cnt - c0 != 1) begin miscmp++; $display("FAIL sfifo_pop got=%0d exp=1", rd_cnt - c0); end
    sf_empty = 1; c0 = rd_cnt;
    xfer(0, 6'd2, 0, 4'hF, 20, d, a, e, n);
    repeat (2) @(posedge clk);
    vec++; if (e !== 1 || a !== 0 || n != 8) begin miscmp++; $display("FAIL sfifo_tmo got err=%b ack=%b n=%0d exp err=1 ack=0 n=8", e, a, n); end
    vec++; if (rd_cnt - c0 != 0) begin miscmp++; $display("FAIL tmo_no_pop got=%0d exp=0", rd_cnt - c0); end
    xfer(0, 6'd5, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 1) begin miscmp++; $display("FAIL err_sticky got=%h exp=1", d); end
    xfer(0, 6'd1, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 32'h31) begin miscmp++; $display("FAIL status_tmo got=%h exp=31", d); end
    xfer(1, 6'd5, 1, 4'hF, 20, d, a, e, n);
    xfer(0, 6'd5, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 0) begin miscmp++; $display("FAIL err_clear got=%h exp=0", d); end
  endtask
  task automatic test_mbox();
    q0 = mq.size();
    xfer(1, 6'd3, 32'h11223344, 4'hF, 20, d, a, e, n);
    @(posedge clk); #1 mb_full = 1;
    repeat (3) @(posedge clk);
    #1 mb_full = 0;
    repeat (8) @(posedge clk);
    vec++; if (a !== 1 || n != 1) begin miscmp++; $display("FAIL mbox_ack got ack=%b n=%0d exp ack=1 n=1", a, n); end
    vec++; if (mq.size() - q0 != 4 || {mq[q0], mq[q0+1], mq[q0+2], mq[q0+3]} !== 32'h44332211) begin miscmp++; $display("FAIL mbox_full_seq got size=%0d exp 44 33 22 11", mq.size() - q0); end
    vec++; if (mb_bad != 0) begin miscmp++; $display("FAIL mbox_wr_while_full got=%0d exp=0", mb_bad); end
    q0 = mq.size();
    xfer(1, 6'd3, 32'hAABBCCDD, 4'h5, 20, d, a, e, n);
    repeat (8) @(posedge clk);
    vec++; if (mq.size() - q0 != 2 || {mq[q0], mq[q0+1]} !== 16'hDDBB) begin miscmp++; $display("FAIL mbox_sel5 got size=%0d exp DD BB", mq.size() - q0); end
    q0 = mq.size();
    xfer(1, 6'd3, 32'h12345678, 4'h0, 20, d, a, e, n);
    repeat (6) @(posedge clk);
    vec++; if (a !== 1 || mq.size() != q0) begin miscmp++; $display("FAIL mbox_sel0 got ack=%b bytes=%0d exp ack=1 bytes=0", a, mq.size() - q0); end
    mb_full = 1;
    xfer(1, 6'd3, 32'h12345678, 4'hF, 5, d, a, e, n);
    mb_full = 0;
    repeat (3) @(posedge clk);
    vec++; if (a !== 0 || mq.size() != q0) begin miscmp++; $display("FAIL mbox_full_stall got ack=%b bytes=%0d exp ack=0 bytes=0", a, mq.size() - q0); end
  endtask
  task automatic test_back_to_back();
    int k;
    q0 = mq.size();
    xfer(1, 6'd3, 32'h04030201, 4'hF, 20, d, a, e, n);
    xfer(1, 6'd3, 32'h55667788, 4'hF, 20, d, a, e, n);
    repeat (8) @(posedge clk);
    vec++; if (a !== 1 || n != 4) begin miscmp++; $display("FAIL mbox_busy_stall got ack=%b n=%0d exp ack=1 n=4", a, n); end
    vec++; if (mq.size() - q0 != 8 || {mq[q0], mq[q0+1], mq[q0+2], mq[q0+3], mq[q0+4], mq[q0+5], mq[q0+6], mq[q0+7]} !== 64'h0102030488776655) begin miscmp++; $display("FAIL mbox_two_words got size=%0d exp 01..04 88..55", mq.size() - q0); end
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = 6'd1;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) k++;
    end
    cyc = 0; stb = 0;
    vec++; if (k != 3) begin miscmp++; $display("FAIL held_strobe_acks got=%0d exp=3", k); end
  endtask
  task automatic test_dout();
    xfer(1, 6'h10, 32'h000000F0, 4'hF, 20, d, a, e, n);
    xfer(1, 6'h0C, 32'h0000000F, 4'hF, 20, d, a, e, n);
    vec++; if (dout !== 32'h0000000F) begin miscmp++; $display("FAIL dout_write got=%h exp=0000000f", dout); end
    xfer(1, 6'h0C, 32'hAABBCCDD, 4'h6, 20, d, a, e, n);
    vec++; if (dout !== 32'h00BBCC0F) begin miscmp++; $display("FAIL dout_bytes got=%h exp=00bbcc0f", dout); end
    xfer(1, 6'h0D, 32'hFFFFFFFF, 4'hF, 20, d, a, e, n);
    vec++; if (dout !== 32'h00BBCC0F || a !== 1) begin miscmp++; $display("FAIL dout_oor got=%h ack=%b exp=00bbcc0f ack=1", dout, a); end
    @(posedge clk); #1 alarm = 1;
    @(posedge clk); #1;
    vec++; if (dout !== 32'h000000F0) begin miscmp++; $display("FAIL alarm_load got=%h exp=000000f0", dout); end
    xfer(1, 6'h0C, 32'h000000FF, 4'hF, 20, d, a, e, n);
    @(posedge clk); #1;
    vec++; if (dout !== 32'h000000F0 || a !== 1) begin miscmp++; $display("FAIL alarm_discard got=%h ack=%b exp=000000f0 ack=1", dout, a); end
    alarm = 0;
    xfer(0, 6'h0C, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 32'h000000F0) begin miscmp++; $display("FAIL dout_read got=%h exp=000000f0", d); end
    xfer(0, 6'h10, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 32'h000000F0) begin miscmp++; $display("FAIL estop_read got=%h exp=000000f0", d); end
  endtask
  task automatic test_bp_reset();
    for (int i = 0; i < 5; i++) begin
      bp_tick = 1; repeat (3) @(posedge clk);
      bp_tick = 0; repeat (3) @(posedge clk);
    end
    repeat (4) @(posedge clk);
    xfer(0, 6'd0, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 32'd5) begin miscmp++; $display("FAIL bp_tick got=%h exp=5", d); end
    q0 = mq.size();
    xfer(1, 6'd3, 32'hA1B2C3D4, 4'hF, 20, d, a, e, n);
    @(posedge clk); #1 rst_n = 0;
    #1;
    vec++; if ({dat_o, ack, err, sf_rd, mb_wr, mb_do, rt_rst, dout} !== '0) begin miscmp++; $display("FAIL midsend_reset got=%h %b%b%b%b %h %b %h exp=all zero", dat_o, ack, err, sf_rd, mb_wr, mb_do, rt_rst, dout); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (6) @(posedge clk);
    vec++; if (mq.size() - q0 != 1 || mq[q0] !== 8'hD4) begin miscmp++; $display("FAIL dropped_bytes got size=%0d exp=1 (D4)", mq.size() - q0); end
    xfer(0, 6'd0, 0, 4'hF, 20, d, a, e, n);
    vec++; if (d !== 0) begin miscmp++; $display("FAIL bp_after_reset got=%h exp=0", d); end
  endtask
  initial begin
    test_reset();
    test_decode();
    test_sfifo();
    test_mbox();
    test_back_to_back();
    test_dout();
    test_bp_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
